// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_MA    = 4'd2,
    S_MR    = 4'd3,
    S_MWB   = 4'd4,
    S_MW    = 4'd5,
    S_EXE   = 4'd6,
    S_ALUWB = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;

  localparam logic [1:0] SRCA_RS    = 2'd0;
  localparam logic [1:0] SRCA_SHAMT = 2'd1;
  localparam logic [1:0] SRCA_ZERO  = 2'd2;

  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_DM  = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_JMP = 2'd2;
  localparam logic [1:0] NPC_RS  = 2'd3;

  // One-hot instruction classification; illegal is set for anything unsupported.
  typedef struct packed {
    logic is_addu;
    logic is_subu;
    logic is_and;
    logic is_or;
    logic is_srl;
    logic is_srlv;
    logic is_jr;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bgez;
    logic is_j;
    logic is_jal;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Datapath <-> control signal bundle. The datapath side is master, the control unit is slave.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic [4:0] Rt;
  logic       Zero;
  logic       Zero2;
  logic       PCWr;
  logic       IRWr;
  logic       RFWr;
  logic       DMWr;
  logic [2:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ExtOp;
  logic [1:0] RegDst;
  logic [1:0] MemToReg;
  logic [1:0] NPCSel;
  logic [3:0] State;

  modport master (
    output Op, Funct, Rt, Zero, Zero2,
    input  PCWr, IRWr, RFWr, DMWr, ALUOp, ALUSrcA, ALUSrcB, ExtOp,
           RegDst, MemToReg, NPCSel, State
  );

  modport slave (
    input  Op, Funct, Rt, Zero, Zero2,
    output PCWr, IRWr, RFWr, DMWr, ALUOp, ALUSrcA, ALUSrcB, ExtOp,
           RegDst, MemToReg, NPCSel, State
  );
endinterface

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction classifier: IR fields to one-hot flags.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output dec_t       dec
);

  // Classify by opcode, then by funct for R-type and by rt for REGIMM.
  always_comb begin
    dec = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: dec.is_addu = 1'b1;
          FN_SUBU: dec.is_subu = 1'b1;
          FN_AND:  dec.is_and  = 1'b1;
          FN_OR:   dec.is_or   = 1'b1;
          FN_SRL:  dec.is_srl  = 1'b1;
          FN_SRLV: dec.is_srlv = 1'b1;
          FN_JR:   dec.is_jr   = 1'b1;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BGEZ) dec.is_bgez = 1'b1;
        else               dec.illegal = 1'b1;
      end
      OP_J:    dec.is_j    = 1'b1;
      OP_JAL:  dec.is_jal  = 1'b1;
      OP_BEQ:  dec.is_beq  = 1'b1;
      OP_ORI:  dec.is_ori  = 1'b1;
      OP_LUI:  dec.is_lui  = 1'b1;
      OP_LW:   dec.is_lw   = 1'b1;
      OP_SW:   dec.is_sw   = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore control FSM for the MIPS datapath.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic  Clk,
  input  logic  Reset,
  mc_ctrl_if.slave bus
);

  dec_t   dec;
  state_t state_q, state_d;

  logic is_rtype_alu;
  logic pc_wr, ir_wr, rf_wr, dm_wr;
  logic [2:0] alu_op, exe_alu_op;
  logic [1:0] src_a, src_b, ext_op, reg_dst, mem_to_reg, npc_sel;
  logic [1:0] exe_src_a, exe_src_b, exe_ext_op;

  mc_ctrl_dec u_dec (
    .op    (bus.Op),
    .funct (bus.Funct),
    .rt    (bus.Rt),
    .dec   (dec)
  );

  assign is_rtype_alu = dec.is_addu | dec.is_subu | dec.is_and | dec.is_or |
                        dec.is_srl  | dec.is_srlv;

  // Next-state selection; DCD dispatches on the instruction class.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DCD;
      S_DCD: begin
        if (dec.is_lw | dec.is_sw)                              state_d = S_MA;
        else if (is_rtype_alu | dec.is_ori | dec.is_lui)        state_d = S_EXE;
        else if (dec.is_beq | dec.is_bgez)                      state_d = S_BR;
        else if (dec.is_j | dec.is_jal | dec.is_jr)             state_d = S_JMP;
        else                                                    state_d = S_FETCH;
      end
      S_MA:    state_d = dec.is_lw ? S_MR : S_MW;
      S_MR:    state_d = S_MWB;
      S_EXE:   state_d = S_ALUWB;
      default: state_d = S_FETCH;
    endcase
  end

  // State register; reset drops straight back to FETCH.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // ALU selects for EXE, held through ALUWB so the result stays valid at write-back.
  always_comb begin
    exe_alu_op = ALU_ADD;
    exe_src_a  = SRCA_RS;
    exe_src_b  = SRCB_RT;
    exe_ext_op = EXT_ZERO;
    if (dec.is_subu) exe_alu_op = ALU_SUB;
    if (dec.is_and)  exe_alu_op = ALU_AND;
    if (dec.is_or)   exe_alu_op = ALU_OR;
    if (dec.is_srl) begin
      exe_alu_op = ALU_SRL;
      exe_src_a  = SRCA_SHAMT;
    end
    if (dec.is_srlv) exe_alu_op = ALU_SRL;
    if (dec.is_ori) begin
      exe_alu_op = ALU_OR;
      exe_src_b  = SRCB_IMM;
    end
    if (dec.is_lui) begin
      exe_src_a  = SRCA_ZERO;
      exe_src_b  = SRCB_IMM;
      exe_ext_op = EXT_UPPER;
    end
  end

  // Moore outputs decoded from the current state and instruction flags.
  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    rf_wr      = 1'b0;
    dm_wr      = 1'b0;
    alu_op     = ALU_ADD;
    src_a      = SRCA_RS;
    src_b      = SRCB_RT;
    ext_op     = EXT_ZERO;
    reg_dst    = DST_RT;
    mem_to_reg = M2R_ALU;
    npc_sel    = NPC_SEQ;
    case (state_q)
      S_FETCH: begin
        pc_wr = 1'b1;
        ir_wr = 1'b1;
      end
      S_MA, S_MR, S_MW: begin
        src_b  = SRCB_IMM;
        ext_op = EXT_SIGN;
        dm_wr  = (state_q == S_MW);
      end
      S_MWB: begin
        rf_wr      = 1'b1;
        mem_to_reg = M2R_DM;
      end
      S_EXE, S_ALUWB: begin
        alu_op = exe_alu_op;
        src_a  = exe_src_a;
        src_b  = exe_src_b;
        ext_op = exe_ext_op;
        if (state_q == S_ALUWB) begin
          rf_wr   = 1'b1;
          reg_dst = is_rtype_alu ? DST_RD : DST_RT;
        end
      end
      S_BR: begin
        alu_op  = ALU_SUB;
        ext_op  = EXT_SIGN;
        npc_sel = NPC_BR;
        pc_wr   = (dec.is_beq & bus.Zero) | (dec.is_bgez & bus.Zero2);
      end
      S_JMP: begin
        pc_wr   = 1'b1;
        npc_sel = dec.is_jr ? NPC_RS : NPC_JMP;
        if (dec.is_jal) begin
          rf_wr      = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = M2R_PC;
        end
      end
      default: ;
    endcase
  end

  // Enables are suppressed for as long as reset is held, even though FETCH would assert them.
  assign bus.PCWr     = pc_wr & ~Reset;
  assign bus.IRWr     = ir_wr & ~Reset;
  assign bus.RFWr     = rf_wr & ~Reset;
  assign bus.DMWr     = dm_wr & ~Reset;
  assign bus.ALUOp    = alu_op;
  assign bus.ALUSrcA  = src_a;
  assign bus.ALUSrcB  = src_b;
  assign bus.ExtOp    = ext_op;
  assign bus.RegDst   = reg_dst;
  assign bus.MemToReg = mem_to_reg;
  assign bus.NPCSel   = npc_sel;
  assign bus.State    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class state by state.
module tb_mc_ctrl;

  logic Clk;
  logic Reset;
  int   n_vec;
  int   n_mis;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Packed output word: {State, PCWr, IRWr, RFWr, DMWr, ALUOp, SrcA, SrcB, Ext, RegDst, MemToReg, NPCSel}
  function automatic logic [22:0] pk(input logic [3:0] st, input logic pc, input logic ir,
                                     input logic rf, input logic dm, input logic [2:0] alu,
                                     input logic [1:0] a, input logic [1:0] b, input logic [1:0] e,
                                     input logic [1:0] rd, input logic [1:0] m2r, input logic [1:0] npc);
    return {st, pc, ir, rf, dm, alu, a, b, e, rd, m2r, npc};
  endfunction

  function automatic logic [22:0] observed();
    return pk(bus.State, bus.PCWr, bus.IRWr, bus.RFWr, bus.DMWr, bus.ALUOp, bus.ALUSrcA,
              bus.ALUSrcB, bus.ExtOp, bus.RegDst, bus.MemToReg, bus.NPCSel);
  endfunction

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic stp(input string tag, input logic [22:0] exp);
    @(posedge Clk);
    #1;
    chk(tag, observed(), exp);
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
    bus.Op    = op;
    bus.Funct = fn;
    bus.Rt    = rt;
  endtask

  logic [22:0] V_RST, V_F, V_D, V_MA, V_MR, V_MWB, V_MW;

  initial begin
    n_vec = 0;
    n_mis = 0;
    V_RST = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    V_F   = pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    V_D   = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    V_MA  = pk(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    V_MR  = pk(3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    V_MWB = pk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    V_MW  = pk(5, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);

    Reset     = 1'b1;
    bus.Zero  = 1'b0;
    bus.Zero2 = 1'b0;
    instr(6'b100011, 6'b000000, 5'b00000);
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_hold", observed(), V_RST);
    Reset = 1'b0;
    #1;
    chk("rst_rel_fetch", observed(), V_F);

    // lw: 5 states
    stp("lw_dcd", V_D);
    stp("lw_ma", V_MA);
    stp("lw_mr", V_MR);
    stp("lw_mwb", V_MWB);
    stp("lw_fetch", V_F);

    // lw interrupted by reset in MR
    stp("lw2_dcd", V_D);
    stp("lw2_ma", V_MA);
    stp("lw2_mr", V_MR);
    Reset = 1'b1;
    #1;
    chk("rst_mid_mr", observed(), V_RST);
    @(posedge Clk);
    #1;
    chk("rst_mid_hold", observed(), V_RST);
    Reset = 1'b0;
    #1;
    chk("rst_mid_rel", observed(), V_F);
    stp("lw3_dcd", V_D);
    stp("lw3_ma", V_MA);
    stp("lw3_mr", V_MR);
    stp("lw3_mwb", V_MWB);
    stp("lw3_fetch", V_F);

    // sw: 4 states
    instr(6'b101011, 6'b000000, 5'b00000);
    stp("sw_dcd", V_D);
    stp("sw_ma", V_MA);
    stp("sw_mw", V_MW);
    stp("sw_fetch", V_F);

    // srl: shamt on A, rd destination
    instr(6'b000000, 6'b000010, 5'b00000);
    stp("srl_dcd", V_D);
    stp("srl_exe", pk(6, 0, 0, 0, 0, 3'b100, 1, 0, 0, 0, 0, 0));
    stp("srl_wb", pk(7, 0, 0, 1, 0, 3'b100, 1, 0, 0, 1, 0, 0));
    stp("srl_fetch", V_F);

    // srlv: shift by rs
    instr(6'b000000, 6'b000110, 5'b00000);
    stp("srlv_dcd", V_D);
    stp("srlv_exe", pk(6, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 0, 0));
    stp("srlv_wb", pk(7, 0, 0, 1, 0, 3'b100, 0, 0, 0, 1, 0, 0));
    stp("srlv_fetch", V_F);

    // addu / subu / and / or write-back words
    instr(6'b000000, 6'b100001, 5'b00000);
    stp("addu_dcd", V_D);
    stp("addu_exe", pk(6, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    stp("addu_wb", pk(7, 0, 0, 1, 0, 3'b000, 0, 0, 0, 1, 0, 0));
    stp("addu_fetch", V_F);
    instr(6'b000000, 6'b100011, 5'b00000);
    stp("subu_dcd", V_D);
    stp("subu_exe", pk(6, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    stp("subu_wb", pk(7, 0, 0, 1, 0, 3'b001, 0, 0, 0, 1, 0, 0));
    stp("subu_fetch", V_F);
    instr(6'b000000, 6'b100100, 5'b00000);
    stp("and_dcd", V_D);
    stp("and_exe", pk(6, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0));
    stp("and_wb", pk(7, 0, 0, 1, 0, 3'b010, 0, 0, 0, 1, 0, 0));
    stp("and_fetch", V_F);
    instr(6'b000000, 6'b100101, 5'b00000);
    stp("or_dcd", V_D);
    stp("or_exe", pk(6, 0, 0, 0, 0, 3'b011, 0, 0, 0, 0, 0, 0));
    stp("or_wb", pk(7, 0, 0, 1, 0, 3'b011, 0, 0, 0, 1, 0, 0));
    stp("or_fetch", V_F);

    // ori: zero-extended imm, rt destination
    instr(6'b001101, 6'b000000, 5'b00000);
    stp("ori_dcd", V_D);
    stp("ori_exe", pk(6, 0, 0, 0, 0, 3'b011, 0, 1, 0, 0, 0, 0));
    stp("ori_wb", pk(7, 0, 0, 1, 0, 3'b011, 0, 1, 0, 0, 0, 0));
    stp("ori_fetch", V_F);

    // lui: 0 + (imm<<16)
    instr(6'b001111, 6'b000000, 5'b00000);
    stp("lui_dcd", V_D);
    stp("lui_exe", pk(6, 0, 0, 0, 0, 3'b000, 2, 1, 2, 0, 0, 0));
    stp("lui_wb", pk(7, 0, 0, 1, 0, 3'b000, 2, 1, 2, 0, 0, 0));
    stp("lui_fetch", V_F);

    // beq taken, with Zero already high in DCD (must not write there)
    instr(6'b000100, 6'b000000, 5'b00000);
    bus.Zero = 1'b1;
    stp("beq1_dcd", V_D);
    stp("beq1_br", pk(8, 1, 0, 0, 0, 3'b001, 0, 0, 1, 0, 0, 1));
    stp("beq1_fetch", V_F);
    bus.Zero = 1'b0;
    stp("beq0_dcd", V_D);
    stp("beq0_br", pk(8, 0, 0, 0, 0, 3'b001, 0, 0, 1, 0, 0, 1));
    stp("beq0_fetch", V_F);

    // bgez follows Zero2, not Zero
    instr(6'b000001, 6'b000000, 5'b00001);
    bus.Zero  = 1'b1;
    bus.Zero2 = 1'b0;
    stp("bgez0_dcd", V_D);
    stp("bgez0_br", pk(8, 0, 0, 0, 0, 3'b001, 0, 0, 1, 0, 0, 1));
    stp("bgez0_fetch", V_F);
    bus.Zero  = 1'b0;
    bus.Zero2 = 1'b1;
    stp("bgez1_dcd", V_D);
    stp("bgez1_br", pk(8, 1, 0, 0, 0, 3'b001, 0, 0, 1, 0, 0, 1));
    stp("bgez1_fetch", V_F);

    // REGIMM with a different rt is not supported
    instr(6'b000001, 6'b000000, 5'b00000);
    stp("regimm_bad_dcd", V_D);
    stp("regimm_bad_fetch", V_F);
    bus.Zero2 = 1'b0;

    // jumps
    instr(6'b000010, 6'b000000, 5'b00000);
    stp("j_dcd", V_D);
    stp("j_jmp", pk(9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    stp("j_fetch", V_F);
    instr(6'b000011, 6'b000000, 5'b00000);
    stp("jal_dcd", V_D);
    stp("jal_jmp", pk(9, 1, 0, 1, 0, 0, 0, 0, 0, 2, 2, 2));
    stp("jal_fetch", V_F);
    instr(6'b000000, 6'b001000, 5'b00000);
    stp("jr_dcd", V_D);
    stp("jr_jmp", pk(9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    stp("jr_fetch", V_F);

    // illegal opcode and illegal funct fall straight back to FETCH
    instr(6'b111111, 6'b000000, 5'b00000);
    stp("ill_op_dcd", V_D);
    stp("ill_op_fetch", V_F);
    instr(6'b000000, 6'b111111, 5'b00000);
    stp("ill_fn_dcd", V_D);
    stp("ill_fn_fetch", V_F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
